// File: rtl/uart_word_rx.sv
// Oversampling 8N1 UART receiver that pairs bytes (high byte first) into 16-bit words.
// Runs on the system clock with an integer bit-period counter and an inter-byte timeout.
module uart_word_rx #(
  parameter int CLKS_PER_BIT = 434,
  parameter int TIMEOUT_CLKS = 10 * CLKS_PER_BIT * 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        rx,
  output logic [15:0] data,
  output logic        valid,
  output logic        frame_err,
  output logic        busy
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int TW = $clog2(TIMEOUT_CLKS + 1);
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [TW-1:0] T_LIMIT   = TW'(TIMEOUT_CLKS);

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_HIGH} state_t;

  state_t          state, state_n;
  logic            rx_meta, rxs, rxs_prev, primed, armed, fall;
  logic [CW-1:0]   cnt, cnt_n;
  logic [2:0]      bit_idx, bit_n;
  logic [7:0]      shift, shift_n, hi, hi_n;
  logic            byte_idx, bidx_n;
  logic [TW-1:0]   tcnt, tcnt_n;
  logic [15:0]     data_n;
  logic            valid_n, ferr_n;

  // armed only rises once the line has really been seen high after reset, so the
  // synchronizer's preset 1 cannot fake a falling edge on a line held low at release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta  <= 1'b1;
      rxs      <= 1'b1;
      rxs_prev <= 1'b1;
      primed   <= 1'b0;
      armed    <= 1'b0;
    end else begin
      rx_meta  <= rx;
      rxs      <= rx_meta;
      rxs_prev <= rxs;
      primed   <= 1'b1;
      armed    <= armed | (primed & rx_meta);
    end
  end

  assign fall = armed & rxs_prev & ~rxs;
  assign busy = (state != IDLE) | byte_idx;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      bit_idx   <= '0;
      shift     <= '0;
      hi        <= '0;
      byte_idx  <= 1'b0;
      tcnt      <= '0;
      data      <= '0;
      valid     <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      bit_idx   <= bit_n;
      shift     <= shift_n;
      hi        <= hi_n;
      byte_idx  <= bidx_n;
      tcnt      <= tcnt_n;
      data      <= data_n;
      valid     <= valid_n;
      frame_err <= ferr_n;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    bit_n   = bit_idx;
    shift_n = shift;
    hi_n    = hi;
    bidx_n  = byte_idx;
    tcnt_n  = tcnt;
    data_n  = data;
    valid_n = 1'b0;
    ferr_n  = 1'b0;
    case (state)
      IDLE: begin
        // A start edge takes priority over an expiring timeout and keeps the partial word.
        if (fall) begin
          state_n = START;
          cnt_n   = '0;
          tcnt_n  = '0;
        end else if (byte_idx) begin
          if (tcnt == T_LIMIT) begin
            bidx_n = 1'b0;
            tcnt_n = '0;
          end else begin
            tcnt_n = tcnt + 1'b1;
          end
        end
      end
      START: begin
        if (cnt == HALF_LAST) begin
          cnt_n   = '0;
          bit_n   = '0;
          state_n = rxs ? IDLE : DATA;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      DATA: begin
        if (cnt == BIT_LAST) begin
          cnt_n   = '0;
          shift_n = {rxs, shift[7:1]};
          bit_n   = bit_idx + 3'd1;
          if (bit_idx == 3'd7) state_n = STOP;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      STOP: begin
        if (cnt == BIT_LAST) begin
          cnt_n = '0;
          if (rxs) begin
            state_n = IDLE;
            if (!byte_idx) begin
              hi_n   = shift;
              bidx_n = 1'b1;
              tcnt_n = '0;
            end else begin
              data_n  = {hi, shift};
              valid_n = 1'b1;
              bidx_n  = 1'b0;
            end
          end else begin
            ferr_n  = 1'b1;
            bidx_n  = 1'b0;
            state_n = WAIT_HIGH;
          end
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      WAIT_HIGH: begin
        if (rxs) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: doc/uart_word_rx.md
# uart_word_rx

Oversampling UART receiver that reassembles 16-bit words from pairs of 8N1 bytes on the console line, high byte first. It is the receive-side counterpart of the word transmit queue and lets the FPGA accept 16-bit values from the host. The block runs on the system clock with an integer bit-period counter, so no divided UART clock is needed. Completed words drive the hex display data register and any other word consumer.

## Interface
- CLKS_PER_BIT, 434 — system clocks per bit period; must be ≥ 8.
- TIMEOUT_CLKS, 10*CLKS_PER_BIT*4 — maximum idle gap between the first byte's stop-bit sample and the second byte's start edge.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- rx  in  1  raw serial line; idle high; asynchronous to clk.
- data  out  16  last completed word; holds its value until the next word completes.
- valid  out  1  one-cycle pulse when `data` is updated.
- frame_err  out  1  one-cycle pulse on a bad stop bit.
- busy  out  1  high in any state other than IDLE, or while a partial word is held.

## Operation
- Input path: `rx` passes through a two-flop synchronizer initialised to 1. All logic uses the synchronized value `rxs`.
- State machine states: IDLE, START, DATA, STOP, WAIT_HIGH.
- IDLE:
  - Falling edge on `rxs` (previous 1, current 0) → START; clear the bit counter.
- START:
  - After CLKS_PER_BIT/2 cycles (integer division), sample `rxs`.
  - Sample 0 → DATA.
  - Sample 1 → glitch; return to IDLE, no output.
- DATA:
  - Sample `rxs` every CLKS_PER_BIT cycles, 8 samples, LSB first, into the shift register.
  - After the 8th sample → STOP.
- STOP:
  - Sample `rxs` CLKS_PER_BIT cycles after the 8th data sample.
  - Sample 1 with byte_idx=0: store the byte as the high byte, set byte_idx=1, arm the timeout counter, go to IDLE.
  - Sample 1 with byte_idx=1: `data` ← {high, byte}, pulse `valid`, set byte_idx=0, go to IDLE.
  - Sample 0: pulse `frame_err`, discard the byte and any partial word (byte_idx=0), go to WAIT_HIGH.
- WAIT_HIGH:
  - Stay until `rxs`=1, then → IDLE. This prevents a break condition from being read as a start bit.
- Inter-byte timeout:
  - With byte_idx=1 and the FSM in IDLE, the counter increments each cycle.
  - When it reaches TIMEOUT_CLKS, byte_idx ← 0 and the high byte is discarded, with no pulse.
  - The counter clears when START is entered.
- Counters:
  - Bit-period counter width is clog2(CLKS_PER_BIT).
  - Timeout counter width is clog2(TIMEOUT_CLKS+1).
  - Neither counter wraps: each is cleared on every state transition.

## Timing
- Reset values: data=16'h0000, valid=0, frame_err=0, busy=0, state=IDLE, byte_idx=0, both synchronizer flops=1.
- Reset mid-frame aborts immediately. After release, the block needs a fresh falling edge to start; a line already low at release is not a start.
- Sampling points: start edge seen 2 cycles after the `rx` edge (synchronizer delay). Bit n (n=0..7) is sampled at CLKS_PER_BIT/2 + (n+1)·CLKS_PER_BIT cycles after edge detection. The stop bit is sampled at CLKS_PER_BIT/2 + 9·CLKS_PER_BIT.
- `valid` and `frame_err` are asserted on the cycle after the stop sample, for exactly one cycle. `data` changes on the same edge that raises `valid`.
- Back-to-back bytes: the FSM is back in IDLE at mid-stop-bit, so a start edge directly after the stop bit is caught.
- Timeout and start edge on the same cycle: the start wins, and the partial word is kept.
- Tolerates about ±4% baud mismatch, since sampling is at bit centre.

## Test plan
1. CLKS_PER_BIT=16, send 0xA5 then 0x5A with no gap → one `valid` pulse, data=16'hA55A, frame_err never high.
2. Send 0x12, 0x34, 0x56, 0x78 back-to-back → two `valid` pulses: 16'h1234, then 16'h5678.
3. Send 0xFF with stop bit 0, then hold rx low 40 cycles, then send 0x01, 0x02 → one `frame_err` pulse, no `valid` until 16'h0102; `data` unchanged before that.
4. rx low for 5 cycles (< CLKS_PER_BIT/2) → no state change beyond START, back in IDLE, no pulses, busy returns to 0.
5. TIMEOUT_CLKS=200: send 0xAB, idle 250 cycles, send 0xCD, 0xEF → single `valid` with 16'hCDEF; 0xAB never appears.
6. Assert rst_n low mid-DATA of the second byte, release, send 0x11, 0x22 → outputs at reset values during reset, then `valid` with 16'h1122.
